// File: rtl/cache_pkg.sv
// Shared command encodings and controller state type for the associative cache.
package cache_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_FLUSH = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_FILL,
    S_FLUSH_SCAN,
    S_FLUSH_WB,
    S_DONE
  } state_e;

endpackage

// File: rtl/cache_set_array.sv
// Two-way tag/data/valid/dirty/LRU storage: asynchronous compare/read of one set,
// single synchronous write port per entry plus a separate LRU write.
module cache_set_array #(
  parameter int unsigned ramWidth = 8,
  parameter int unsigned addrSize = 8,
  parameter int unsigned setBits  = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [setBits-1:0]           set_i,
  input  logic [addrSize-setBits-1:0]  tag_i,
  output logic                         hit_o,
  output logic                         hitWay_o,
  output logic [1:0]                   valid_o,
  output logic [1:0]                   dirty_o,
  output logic [addrSize-setBits-1:0]  tag0_o,
  output logic [addrSize-setBits-1:0]  tag1_o,
  output logic [ramWidth-1:0]          data0_o,
  output logic [ramWidth-1:0]          data1_o,
  output logic                         lru_o,
  input  logic                         we_i,
  input  logic                         wrWay_i,
  input  logic                         wrValid_i,
  input  logic                         wrDirty_i,
  input  logic [addrSize-setBits-1:0]  wrTag_i,
  input  logic [ramWidth-1:0]          wrData_i,
  input  logic                         lruWe_i,
  input  logic                         lruVal_i
);

  localparam int unsigned SETS = 2 ** setBits;
  localparam int unsigned TW   = addrSize - setBits;

  logic          valid_q [2][SETS];
  logic          dirty_q [2][SETS];
  logic [TW-1:0] tag_q   [2][SETS];
  logic [ramWidth-1:0] data_q [2][SETS];
  logic          lru_q   [SETS];

  logic hit0, hit1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
      lru_q   <= '{default: '0};
    end else begin
      if (we_i) begin
        valid_q[wrWay_i][set_i] <= wrValid_i;
        dirty_q[wrWay_i][set_i] <= wrDirty_i;
        tag_q[wrWay_i][set_i]   <= wrTag_i;
        data_q[wrWay_i][set_i]  <= wrData_i;
      end
      if (lruWe_i) lru_q[set_i] <= lruVal_i;
    end
  end

  always_comb begin
    hit0     = valid_q[0][set_i] && (tag_q[0][set_i] == tag_i);
    hit1     = valid_q[1][set_i] && (tag_q[1][set_i] == tag_i);
    hit_o    = hit0 || hit1;
    hitWay_o = !hit0;
    valid_o  = {valid_q[1][set_i], valid_q[0][set_i]};
    dirty_o  = {dirty_q[1][set_i], dirty_q[0][set_i]};
    tag0_o   = tag_q[0][set_i];
    tag1_o   = tag_q[1][set_i];
    data0_o  = data_q[0][set_i];
    data1_o  = data_q[1][set_i];
    lru_o    = lru_q[set_i];
  end

endmodule

// File: rtl/assoc_cache_memory.sv
// 2-way set-associative write-back/write-allocate cache with flush, backing-RAM
// req/ready handshake and saturating hit/miss counters.
module assoc_cache_memory
  import cache_pkg::*;
#(
  parameter int unsigned ramWidth = 8,
  parameter int unsigned addrSize = 8,
  parameter int unsigned setBits  = 3,
  parameter int unsigned cntWidth = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [1:0]          cntrl,
  input  logic [addrSize-1:0] addr,
  input  logic [ramWidth-1:0] dataIn,
  output logic [ramWidth-1:0] dataOut,
  output logic                busy,
  output logic                done,
  output logic                hit,
  output logic [addrSize-1:0] memAddr,
  output logic [ramWidth-1:0] memWData,
  output logic                memRead,
  output logic                memWrite,
  input  logic [ramWidth-1:0] memRData,
  input  logic                memReady,
  output logic [cntWidth-1:0] hitCount,
  output logic [cntWidth-1:0] missCount
);

  localparam int unsigned TW = addrSize - setBits;

  state_e              state_q;
  cmd_e                cmd_q;
  logic [addrSize-1:0] addr_q;
  logic [ramWidth-1:0] data_q, dataOut_q, memWData_q;
  logic [addrSize-1:0] memAddr_q;
  logic [setBits:0]    idx_q;
  logic                victim_q, wasHit_q, busy_q, done_q, hit_q, memRead_q, memWrite_q;
  logic [cntWidth-1:0] hitCnt_q, missCnt_q;

  logic                flushing;
  logic [setBits-1:0]  arrSet;
  logic                arrHit, arrHitWay, arrLru;
  logic [1:0]          arrValid, arrDirty;
  logic [TW-1:0]       arrTag0, arrTag1;
  logic [ramWidth-1:0] arrData0, arrData1;
  logic                we, wrWay, wrValid, wrDirty, lruWe, lruVal;
  logic [TW-1:0]       wrTag;
  logic [ramWidth-1:0] wrData;
  logic                vict, fw, entDirty;
  logic [TW-1:0]       entTag, victTag;
  logic [ramWidth-1:0] entData, victData, hitData;

  // During a flush the scan index {set, way} drives the array instead of the command address
  assign flushing = (state_q == S_FLUSH_SCAN) || (state_q == S_FLUSH_WB);
  assign arrSet   = flushing ? idx_q[setBits:1] : addr_q[setBits-1:0];
  assign fw       = idx_q[0];

  cache_set_array #(
    .ramWidth(ramWidth),
    .addrSize(addrSize),
    .setBits (setBits)
  ) u_array (
    .clk_i    (clk),
    .rst_i    (clr),
    .set_i    (arrSet),
    .tag_i    (addr_q[addrSize-1:setBits]),
    .hit_o    (arrHit),
    .hitWay_o (arrHitWay),
    .valid_o  (arrValid),
    .dirty_o  (arrDirty),
    .tag0_o   (arrTag0),
    .tag1_o   (arrTag1),
    .data0_o  (arrData0),
    .data1_o  (arrData1),
    .lru_o    (arrLru),
    .we_i     (we),
    .wrWay_i  (wrWay),
    .wrValid_i(wrValid),
    .wrDirty_i(wrDirty),
    .wrTag_i  (wrTag),
    .wrData_i (wrData),
    .lruWe_i  (lruWe),
    .lruVal_i (lruVal)
  );

  always_comb begin
    vict     = !arrValid[0] ? 1'b0 : (!arrValid[1] ? 1'b1 : arrLru);
    entDirty = arrDirty[fw] && arrValid[fw];
    entTag   = fw ? arrTag1 : arrTag0;
    entData  = fw ? arrData1 : arrData0;
    victTag  = victim_q ? arrTag1 : arrTag0;
    victData = victim_q ? arrData1 : arrData0;
    hitData  = arrHitWay ? arrData1 : arrData0;
  end

  always_comb begin
    we      = 1'b0;
    wrWay   = 1'b0;
    wrValid = 1'b0;
    wrDirty = 1'b0;
    wrTag   = addr_q[addrSize-1:setBits];
    wrData  = data_q;
    lruWe   = 1'b0;
    lruVal  = 1'b0;
    case (state_q)
      S_LOOKUP: if (arrHit) begin
        lruWe  = 1'b1;
        lruVal = !arrHitWay;
        if (cmd_q == CMD_WRITE) begin
          we      = 1'b1;
          wrWay   = arrHitWay;
          wrValid = 1'b1;
          wrDirty = 1'b1;
        end
      end
      S_FILL: if (memRead_q && memReady) begin
        we      = 1'b1;
        wrWay   = victim_q;
        wrValid = 1'b1;
        wrDirty = (cmd_q == CMD_WRITE);
        wrData  = (cmd_q == CMD_WRITE) ? data_q : memRData;
        lruWe   = 1'b1;
        lruVal  = !victim_q;
      end
      S_FLUSH_WB: if (memWrite_q && memReady) begin
        we      = 1'b1;
        wrWay   = fw;
        wrValid = 1'b1;
        wrTag   = entTag;
        wrData  = entData;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_NOP;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      victim_q   <= 1'b0;
      wasHit_q   <= 1'b0;
      dataOut_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      memAddr_q  <= '0;
      memWData_q <= '0;
      hitCnt_q   <= '0;
      missCnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      hit_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (start && (cntrl != CMD_NOP)) begin
          addr_q   <= addr;
          data_q   <= dataIn;
          cmd_q    <= cmd_e'(cntrl);
          busy_q   <= 1'b1;
          wasHit_q <= 1'b0;
          idx_q    <= '0;
          state_q  <= (cntrl == CMD_FLUSH) ? S_FLUSH_SCAN : S_LOOKUP;
        end
        S_LOOKUP: begin
          wasHit_q <= arrHit;
          if (arrHit) begin
            if (cmd_q == CMD_READ) dataOut_q <= hitData;
            if (hitCnt_q != '1) hitCnt_q <= hitCnt_q + cntWidth'(1);
            state_q <= S_DONE;
          end else begin
            if (missCnt_q != '1) missCnt_q <= missCnt_q + cntWidth'(1);
            victim_q <= vict;
            state_q  <= (arrValid[vict] && arrDirty[vict]) ? S_WRITEBACK : S_FILL;
          end
        end
        S_WRITEBACK: if (!memWrite_q) begin
          memWrite_q <= 1'b1;
          memAddr_q  <= {victTag, addr_q[setBits-1:0]};
          memWData_q <= victData;
        end else if (memReady) begin
          memWrite_q <= 1'b0;
          state_q    <= S_FILL;
        end
        S_FILL: if (!memRead_q) begin
          memRead_q <= 1'b1;
          memAddr_q <= addr_q;
        end else if (memReady) begin
          memRead_q <= 1'b0;
          if (cmd_q == CMD_READ) dataOut_q <= memRData;
          state_q <= S_DONE;
        end
        S_FLUSH_SCAN: begin
          if (entDirty) state_q <= S_FLUSH_WB;
          else if (idx_q == '1) state_q <= S_DONE;
          else idx_q <= idx_q + (setBits + 1)'(1);
        end
        S_FLUSH_WB: if (!memWrite_q) begin
          memWrite_q <= 1'b1;
          memAddr_q  <= {entTag, idx_q[setBits:1]};
          memWData_q <= entData;
        end else if (memReady) begin
          memWrite_q <= 1'b0;
          if (idx_q == '1) state_q <= S_DONE;
          else begin
            idx_q   <= idx_q + (setBits + 1)'(1);
            state_q <= S_FLUSH_SCAN;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          hit_q   <= wasHit_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dataOut   = dataOut_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hit       = hit_q;
  assign memAddr   = memAddr_q;
  assign memWData  = memWData_q;
  assign memRead   = memRead_q;
  assign memWrite  = memWrite_q;
  assign hitCount  = hitCnt_q;
  assign missCount = missCnt_q;

endmodule

// File: tb/tb_assoc_cache_memory.sv
// Directed bench for assoc_cache_memory (setBits=3, cntWidth=4) with a latency-programmable RAM responder.
module tb_assoc_cache_memory;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cntrl = 2'b00;
  logic [7:0] addr = '0, dataIn = '0, memRData = '0;
  logic       memReady = 1'b0;
  logic [7:0] dataOut, memAddr, memWData;
  logic       busy, done, hit, memRead, memWrite;
  logic [3:0] hitCount, missCount;

  int checks = 0;
  int failures = 0;

  int         req_n;
  logic       req_w [8];
  logic [7:0] req_a [8];
  logic [7:0] req_d [8];
  logic       got_done, done_hit;
  logic [7:0] done_data;
  int         done_cyc;
  int         both_err = 0;
  int         stray;
  logic       seen;

  always #5 clk = ~clk;

  assoc_cache_memory #(
    .ramWidth(8),
    .addrSize(8),
    .setBits (3),
    .cntWidth(4)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .cntrl(cntrl), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut), .busy(busy), .done(done), .hit(hit), .memAddr(memAddr),
    .memWData(memWData), .memRead(memRead), .memWrite(memWrite), .memRData(memRData),
    .memReady(memReady), .hitCount(hitCount), .missCount(missCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and act as the backing RAM until done or the budget runs out
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d,
                         input int lat, input logic [7:0] rd, input bit poke, input int budget);
    int  k = 0;
    bit  infl = 0;
    int  cyc = 0;
    req_n = 0; got_done = 0; done_hit = 0; done_data = '0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; cntrl = c; addr = a; dataIn = d;
    @(negedge clk);
    start = 1'b0; cntrl = 2'b00;
    while (!got_done && cyc < budget) begin
      if (poke && cyc == 1) begin start = 1'b1; cntrl = 2'b10; addr = 8'h99; end
      if (poke && cyc == 2) begin start = 1'b0; cntrl = 2'b00; end
      memReady = 1'b0;
      if (memRead && memWrite) both_err++;
      if (memRead || memWrite) begin
        if (!infl) begin
          infl = 1; k = 0;
          if (req_n < 8) begin
            req_w[req_n] = memWrite; req_a[req_n] = memAddr; req_d[req_n] = memWData;
          end
          req_n++;
        end else k++;
        if (k == lat) begin memReady = 1'b1; memRData = rd; infl = 0; end
      end
      if (done) begin got_done = 1; done_hit = hit; done_data = dataOut; done_cyc = cyc; end
      if (!got_done) begin @(negedge clk); cyc++; end
    end
    memReady = 1'b0;
    chk("cmd_done", got_done, 1);
  endtask

  task automatic watch_idle(input int n);
    stray = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || done || memRead || memWrite) stray++;
    end
  endtask

  initial begin
    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_memreq", {memRead, memWrite}, 0);
    chk("rst_dataout", dataOut, 0);
    chk("rst_memaddr", {memAddr, memWData}, 0);
    chk("rst_counts", {hitCount, missCount}, 0);
    clr = 1'b0;

    // 1: read miss then read hit
    run_cmd(2'b01, 8'h25, 8'h00, 3, 8'hA7, 0, 40);
    chk("t1_nreq", req_n, 1);
    chk("t1_req", {req_w[0], req_a[0]}, {1'b0, 8'h25});
    chk("t1_hit", done_hit, 0);
    chk("t1_data", done_data, 8'hA7);
    chk("t1_miss", missCount, 1);
    run_cmd(2'b01, 8'h25, 8'h00, 3, 8'h00, 0, 40);
    chk("t1b_nreq", req_n, 0);
    chk("t1b_hit", done_hit, 1);
    chk("t1b_lat", done_cyc, 2);
    chk("t1b_data", done_data, 8'hA7);
    chk("t1b_hitcnt", hitCount, 1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_counts", {hitCount, missCount}, 0);

    // 2: three writes into set 5, third evicts dirty LRU line 0x05
    run_cmd(2'b10, 8'h05, 8'h11, 1, 8'h5A, 0, 40);
    chk("t2a_req", {req_n[3:0], req_w[0], req_a[0]}, {4'd1, 1'b0, 8'h05});
    run_cmd(2'b10, 8'h0D, 8'h22, 1, 8'h5A, 0, 40);
    chk("t2b_req", {req_n[3:0], req_w[0], req_a[0]}, {4'd1, 1'b0, 8'h0D});
    run_cmd(2'b10, 8'h15, 8'h33, 1, 8'h5A, 0, 40);
    chk("t2c_nreq", req_n, 2);
    chk("t2c_wb", {req_w[0], req_a[0], req_d[0]}, {1'b1, 8'h05, 8'h11});
    chk("t2c_fill", {req_w[1], req_a[1]}, {1'b0, 8'h15});
    chk("t2c_hit", done_hit, 0);
    chk("t2_miss", missCount, 3);
    run_cmd(2'b01, 8'h0D, 8'h00, 1, 8'h5A, 0, 40);
    chk("t2d_rdhit", {req_n[3:0], done_hit, done_data}, {4'd0, 1'b1, 8'h22});

    // 3: flush writes back both dirty lines in set/way order, second flush is clean
    run_cmd(2'b11, 8'h00, 8'h00, 2, 8'h00, 0, 80);
    chk("t3_nreq", req_n, 2);
    chk("t3_wb0", {req_w[0], req_a[0], req_d[0]}, {1'b1, 8'h15, 8'h33});
    chk("t3_wb1", {req_w[1], req_a[1], req_d[1]}, {1'b1, 8'h0D, 8'h22});
    chk("t3_hit", done_hit, 0);
    chk("t3_counts", {hitCount, missCount}, {4'd1, 4'd3});
    run_cmd(2'b11, 8'h00, 8'h00, 2, 8'h00, 0, 80);
    chk("t3b_nreq", req_n, 0);
    chk("t3b_lat", done_cyc, 17);
    run_cmd(2'b01, 8'h15, 8'h00, 1, 8'h00, 0, 40);
    chk("t3c_kept", {req_n[3:0], done_hit, done_data}, {4'd0, 1'b1, 8'h33});

    // 4: clr while memRead pending
    @(negedge clk);
    start = 1'b1; cntrl = 2'b01; addr = 8'h40;
    @(negedge clk);
    start = 1'b0; cntrl = 2'b00;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (memRead) seen = 1; else @(negedge clk);
    end
    chk("t4_memread_up", seen, 1);
    clr = 1'b1;
    #1;
    chk("t4_memread_drop", memRead, 0);
    chk("t4_busy", busy, 0);
    @(negedge clk); clr = 1'b0;
    watch_idle(5);
    chk("t4_no_done", stray, 0);
    run_cmd(2'b01, 8'h40, 8'h00, 2, 8'hC4, 1, 40);
    chk("t4b_req", {req_n[3:0], req_w[0], req_a[0]}, {4'd1, 1'b0, 8'h40});
    chk("t4b_hit", {done_hit, done_data}, {1'b0, 8'hC4});

    // 5: start during busy and nop start ignored, then hit counter saturation
    watch_idle(4);
    chk("t5_poke_ignored", stray, 0);
    @(negedge clk); start = 1'b1; cntrl = 2'b00; addr = 8'h40;
    @(negedge clk); start = 1'b0;
    watch_idle(4);
    chk("t5_nop_ignored", stray, 0);
    chk("t5_counts", {hitCount, missCount}, {4'd0, 4'd1});
    for (int i = 0; i < 17; i++) run_cmd(2'b01, 8'h40, 8'h00, 1, 8'h00, 0, 20);
    chk("t5_hitsat", hitCount, 4'hF);
    chk("t5_miss_keep", missCount, 1);
    chk("t5_data", dataOut, 8'hC4);
    chk("no_rw_overlap", both_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
